// File: rtl/multi_timer_pkg.sv
// Shared definitions for multi_timer: register offsets, CTRL field positions, mode encodings.
// Optional prescaler is built only when MULTI_TIMER_PRESCALER_EN is defined.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    // Codes 10 and 11 behave as one-shot but are stored so they read back unchanged.
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_RSVD2   = 2'b10,
        MODE_RSVD3   = 2'b11
    } mode_e;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM       = 3;
    localparam int unsigned CTRL_PSC_LSB  = 4;
    localparam int unsigned CTRL_PSC_MSB  = 11;
    localparam int unsigned PSC_W         = 8;
    localparam int unsigned STATUS_PEND   = 0;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL fields, preset, count, optional prescaler, pending flag.
// Prescaler logic exists only when MULTI_TIMER_PRESCALER_EN is defined; otherwise it ticks every clock.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        wr_preset,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_word,
    output logic [31:0] preset_word,
    output logic [31:0] count_word,
    output logic        pending,
    output logic        irq
);

    logic             enable;
    mode_e            mode;
    logic             im;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [PSC_W-1:0] psc;
    logic             tick;
    logic             terminal;
    logic             reload;
    logic             unused_wdata;

    // Only the CTRL, PRESET and STATUS fields are consumed; the rest of the bus is don't-care.
    assign unused_wdata = ^wdata;

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PSC_W-1:0] pscnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            psc   <= '0;
            pscnt <= '0;
        end else begin
            if (wr_ctrl) begin
                psc <= wdata[CTRL_PSC_MSB:CTRL_PSC_LSB];
            end
            if (!enable || tick) begin
                pscnt <= '0;
            end else begin
                pscnt <= pscnt + PSC_W'(1);
            end
        end
    end

    // >= so that lowering psc below the running prescale count cannot stall the channel
    assign tick = enable && (pscnt >= psc);
`else
    assign psc  = '0;
    assign tick = enable;
`endif

    assign reload   = (mode == MODE_RELOAD);
    assign terminal = tick && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            enable  <= 1'b0;
            mode    <= MODE_ONESHOT;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable <= wdata[CTRL_EN];
                mode   <= mode_e'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                im     <= wdata[CTRL_IM];
            end else if (terminal && !reload) begin
                enable <= 1'b0;
            end

            if (wr_preset) begin
                preset <= wdata[CNT_W-1:0];
                count  <= wdata[CNT_W-1:0];
            end else if (terminal) begin
                count <= reload ? preset : '0;
            end else if (tick && (count > CNT_W'(1))) begin
                count <= count - CNT_W'(1);
            end

            // A terminal tick outranks a write-1-to-clear landing in the same cycle.
            if (terminal) begin
                pending <= 1'b1;
            end else if (wr_status && wdata[STATUS_PEND]) begin
                pending <= 1'b0;
            end
        end
    end

    assign ctrl_word   = 32'({psc, im, mode, enable});
    assign preset_word = 32'(preset);
    assign count_word  = 32'(count);
    assign irq         = pending && im;

endmodule

// File: rtl/multi_timer.sv
// Bank of N_CH timer channels: address decode, combinational read mux, IRQ aggregation.
// Define MULTI_TIMER_PRESCALER_EN to build the per-channel prescaler.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned CNT_W = 32,
    localparam int unsigned CH_W  = ch_width(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [CH_W+3:2] add_i,
    input  logic            we_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    output logic            IRQ
);

    logic [CH_W-1:0] ch_sel;
    reg_e            reg_sel;
    logic [N_CH-1:0] irq_vec;
    logic [N_CH-1:0] pend_vec;
    logic [31:0]     ctrl_words   [N_CH];
    logic [31:0]     preset_words [N_CH];
    logic [31:0]     count_words  [N_CH];

    assign ch_sel  = add_i[CH_W+3:4];
    assign reg_sel = reg_e'(add_i[3:2]);

    // Indices >= N_CH match no channel, so such writes drop and reads fall back to zero.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic hit;
        assign hit = we_i && (ch_sel == CH_W'(g));

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk_i),
            .rst         (rst_i),
            .wr_ctrl     (hit && (reg_sel == REG_CTRL)),
            .wr_preset   (hit && (reg_sel == REG_PRESET)),
            .wr_status   (hit && (reg_sel == REG_STATUS)),
            .wdata       (dat_i),
            .ctrl_word   (ctrl_words[g]),
            .preset_word (preset_words[g]),
            .count_word  (count_words[g]),
            .pending     (pend_vec[g]),
            .irq         (irq_vec[g])
        );
    end

    always_comb begin
        dat_o = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   dat_o = ctrl_words[i];
                    REG_PRESET: dat_o = preset_words[i];
                    REG_COUNT:  dat_o = count_words[i];
                    REG_STATUS: dat_o = 32'(pend_vec[i]);
                    default:    dat_o = '0;
                endcase
            end
        end
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a default 4x32 instance plus a 3-channel 8-bit instance.
`timescale 1ns/1ps
module tb_multi_timer;
    import multi_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:2]  add;
    logic        we;
    logic [31:0] dat;
    logic [31:0] dout;
    logic        irq;
    logic [5:2]  add_s;
    logic        we_s;
    logic [31:0] dat_s;
    logic [31:0] dout_s;
    logic        irq_s;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] want;

    multi_timer #(.N_CH(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .add_i(add), .we_i(we), .dat_i(dat), .dat_o(dout), .IRQ(irq)
    );

    multi_timer #(.N_CH(3), .CNT_W(8)) dut_s (
        .clk_i(clk), .rst_i(rst), .add_i(add_s), .we_i(we_s), .dat_i(dat_s), .dat_o(dout_s), .IRQ(irq_s)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input reg_e r, input logic [31:0] d);
        add = {2'(ch), r}; we = 1'b1; dat = d;
        step(1);
        we = 1'b0; dat = '0;
    endtask

    task automatic rd(input int ch, input reg_e r, output logic [31:0] d);
        add = {2'(ch), r};
        #1;
        d = dout;
    endtask

    task automatic wr_s(input int ch, input reg_e r, input logic [31:0] d);
        add_s = {2'(ch), r}; we_s = 1'b1; dat_s = d;
        step(1);
        we_s = 1'b0; dat_s = '0;
    endtask

    task automatic rd_s(input int ch, input reg_e r, output logic [31:0] d);
        add_s = {2'(ch), r};
        #1;
        d = dout_s;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; add = '0; dat = '0;
        we_s = 1'b0; add_s = '0; dat_s = '0;
        step(3);
        rst = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) exp_q.push_back(32'h0);
            for (int r = 0; r < 4; r++) begin
                rd(ch, reg_e'(r), got);
                want = exp_q.pop_front(); n_chk++;
                if (got !== want) $display("FAIL reset_ch%0d_reg%0d got %h want %h", ch, r, got, want);
                else n_pass++;
            end
            step(1);
        end
        n_chk++;
        if (irq !== 1'b0 || irq_s !== 1'b0) $display("FAIL reset_irq got %b/%b want 0/0", irq, irq_s);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        wr(0, REG_PRESET, 32'd5);
        wr(0, REG_CTRL, 32'h9);
        for (int k = 4; k >= 0; k--) exp_q.push_back(32'(k));
        n_chk++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_early got %b want 0", irq); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(1);
            rd(0, REG_COUNT, got);
            want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL oneshot_count[%0d] got %0d want %0d", i, got, want);
            else n_pass++;
        end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h8);
        rd(0, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL oneshot_pending got %h want %h", got, want); else n_pass++;
        rd(0, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL oneshot_ctrl got %h want %h", got, want); else n_pass++;
        n_chk++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq got %b want 1", irq); else n_pass++;
        step(1);
        exp_q.push_back(32'h0);
        rd(0, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL oneshot_hold got %h want %h", got, want); else n_pass++;
        wr(0, REG_STATUS, 32'h0);
        exp_q.push_back(32'h1);
        rd(0, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL status_write0 got %h want %h", got, want); else n_pass++;
        wr(0, REG_STATUS, 32'h1);
        exp_q.push_back(32'h0);
        rd(0, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL status_w1c got %h want %h", got, want); else n_pass++;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_clear got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_reload();
        int   mc;
        logic mp;
        wr(1, REG_PRESET, 32'd3);
        wr(1, REG_CTRL, 32'hB);
        mc = 3; mp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (mc == 1) begin mc = 3; mp = 1'b1; end
            else mc = mc - 1;
            exp_q.push_back(32'(mc));
            step(1);
            rd(1, REG_COUNT, got);
            want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL reload_count[%0d] got %0d want %0d", i, got, want);
            else n_pass++;
            n_chk++;
            if (irq !== mp) $display("FAIL reload_irq[%0d] got %b want %b", i, irq, mp); else n_pass++;
        end
        wr(1, REG_STATUS, 32'h1);
        exp_q.push_back(32'd2);
        rd(1, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL reload_w1c_count got %0d want %0d", got, want); else n_pass++;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL reload_w1c_irq got %b want 0", irq); else n_pass++;
        step(1);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL reload_period_early got %b want 0", irq); else n_pass++;
        step(1);
        n_chk++;
        if (irq !== 1'b1) $display("FAIL reload_period_event got %b want 1", irq); else n_pass++;
        wr(1, REG_CTRL, 32'h0);
        wr(1, REG_STATUS, 32'h1);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL reload_stop_irq got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_prescaler();
        wr(2, REG_PRESET, 32'd2);
        wr(2, REG_CTRL, 32'h31);
`ifdef MULTI_TIMER_PRESCALER_EN
        exp_q.push_back(32'h31);
        rd(2, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL psc_ctrl got %h want %h", got, want); else n_pass++;
        for (int k = 1; k <= 8; k++) exp_q.push_back((k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            rd(2, REG_COUNT, got);
            want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL psc_count[%0d] got %0d want %0d", k, got, want);
            else n_pass++;
        end
        exp_q.push_back(32'h30);
`else
        exp_q.push_back(32'h01);
        rd(2, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL nopsc_ctrl got %h want %h", got, want); else n_pass++;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        for (int k = 1; k <= 2; k++) begin
            step(1);
            rd(2, REG_COUNT, got);
            want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL nopsc_count[%0d] got %0d want %0d", k, got, want);
            else n_pass++;
        end
        exp_q.push_back(32'h00);
`endif
        rd(2, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL psc_ctrl_done got %h want %h", got, want); else n_pass++;
        exp_q.push_back(32'h1);
        rd(2, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL psc_pending got %h want %h", got, want); else n_pass++;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL psc_irq_masked got %b want 0", irq); else n_pass++;
        wr(2, REG_STATUS, 32'h1);
    endtask

    task automatic test_races();
        // W1C in the terminal-tick cycle
        wr(0, REG_PRESET, 32'd2);
        wr(0, REG_CTRL, 32'h1);
        step(1);
        wr(0, REG_STATUS, 32'h1);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd(0, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_w1c_pending got %h want %h", got, want); else n_pass++;
        rd(0, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_w1c_count got %h want %h", got, want); else n_pass++;
        rd(0, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_w1c_ctrl got %h want %h", got, want); else n_pass++;
        wr(0, REG_STATUS, 32'h1);
        // preset 0 while enabled: no event
        wr(0, REG_PRESET, 32'd0);
        wr(0, REG_CTRL, 32'h1);
        step(5);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        rd(0, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL zero_count got %h want %h", got, want); else n_pass++;
        rd(0, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL zero_pending got %h want %h", got, want); else n_pass++;
        rd(0, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL zero_ctrl got %h want %h", got, want); else n_pass++;
        wr(0, REG_CTRL, 32'h0);
        // CTRL write in the terminal cycle of a reload channel
        wr(1, REG_PRESET, 32'd2);
        wr(1, REG_CTRL, 32'h3);
        step(1);
        wr(1, REG_CTRL, 32'h2);
        step(2);
        exp_q.push_back(32'h2); exp_q.push_back(32'h1); exp_q.push_back(32'd2);
        rd(1, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_ctrl_ctrl got %h want %h", got, want); else n_pass++;
        rd(1, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_ctrl_pending got %h want %h", got, want); else n_pass++;
        rd(1, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_ctrl_count got %0d want %0d", got, want); else n_pass++;
        wr(1, REG_STATUS, 32'h1);
        // PRESET write in the terminal cycle, then COUNT write ignored
        wr(1, REG_CTRL, 32'h3);
        step(1);
        wr(1, REG_PRESET, 32'd7);
        exp_q.push_back(32'd7); exp_q.push_back(32'h1);
        rd(1, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_preset_count got %0d want %0d", got, want); else n_pass++;
        rd(1, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL race_preset_pending got %h want %h", got, want); else n_pass++;
        wr(1, REG_COUNT, 32'd55);
        exp_q.push_back(32'd6);
        rd(1, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL count_write_ignored got %0d want %0d", got, want); else n_pass++;
        wr(1, REG_CTRL, 32'h0);
        wr(1, REG_STATUS, 32'h1);
    endtask

    task automatic test_reset_midcount();
        wr(3, REG_PRESET, 32'd100);
        wr(3, REG_CTRL, 32'h9);
        step(5);
        exp_q.push_back(32'd95);
        rd(3, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL mid_count got %0d want %0d", got, want); else n_pass++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) exp_q.push_back(32'h0);
        for (int r = 0; r < 4; r++) begin
            rd(3, reg_e'(r), got);
            want = exp_q.pop_front(); n_chk++;
            if (got !== want) $display("FAIL mid_reset_reg%0d got %h want %h", r, got, want);
            else n_pass++;
        end
        n_chk++;
        if (irq !== 1'b0) $display("FAIL mid_reset_irq got %b want 0", irq); else n_pass++;
        step(110);
        exp_q.push_back(32'h0);
        rd(3, REG_STATUS, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL mid_no_pending got %h want %h", got, want); else n_pass++;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL mid_late_irq got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_small();
        wr_s(3, REG_PRESET, 32'h55);
        wr_s(3, REG_CTRL, 32'hF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd_s(3, REG_PRESET, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_bad_ch_preset got %h want %h", got, want); else n_pass++;
        rd_s(3, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_bad_ch_ctrl got %h want %h", got, want); else n_pass++;
        wr_s(0, REG_PRESET, 32'h1FF);
        wr_s(2, REG_PRESET, 32'h3);
        exp_q.push_back(32'hFF); exp_q.push_back(32'hFF); exp_q.push_back(32'h3);
        rd_s(0, REG_PRESET, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_preset_trunc got %h want %h", got, want); else n_pass++;
        rd_s(0, REG_COUNT, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_count_trunc got %h want %h", got, want); else n_pass++;
        rd_s(2, REG_PRESET, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_ch2_preset got %h want %h", got, want); else n_pass++;
        wr_s(1, REG_CTRL, 32'hFFFF_FFF6);
`ifdef MULTI_TIMER_PRESCALER_EN
        exp_q.push_back(32'hFF6);
`else
        exp_q.push_back(32'h006);
`endif
        rd_s(1, REG_CTRL, got);
        want = exp_q.pop_front(); n_chk++;
        if (got !== want) $display("FAIL small_ctrl_mask got %h want %h", got, want); else n_pass++;
        n_chk++;
        if (irq_s !== 1'b0) $display("FAIL small_irq got %b want 0", irq_s); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_prescaler();
        test_races();
        test_reset_midcount();
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
